// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep controller: walks a nonce range through an external SHA block and stops on the first hash below target.
// Optional SHA watchdog is compiled in with `define NONCE_SWEEP_WATCHDOG_EN.
module nonce_sweep_ctrl #(
  parameter int TOTAL_SIZE     = 640,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [TOTAL_SIZE-33:0] header_in,
  input  logic [31:0]           nonce_start,
  input  logic [31:0]           nonce_end,
  input  logic [255:0]          target,
  input  logic                  abort,
  output logic [TOTAL_SIZE-1:0] sha_msg,
  output logic                  sha_begin,
  input  logic                  sha_done,
  input  logic [255:0]          sha_hash,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic                  exhausted,
  output logic                  timeout_err,
  output logic [31:0]           found_nonce,
  output logic [255:0]          found_hash,
  output logic [31:0]           hash_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FINISH} stateT;

  stateT state, nextState;

  logic [TOTAL_SIZE-33:0] headerReg;
  logic [31:0]            curNonce;
  logic [31:0]            endNonce;
  logic [255:0]           targetReg;
  logic [255:0]           hashReg;
  logic                   wdExpired;
  logic                   hit;
  logic                   lastNonce;
  logic                   accept;

  if (TOTAL_SIZE <= 32 || TIMEOUT_CYCLES < 1) begin : gParamCheck
    $error("nonce_sweep_ctrl: TOTAL_SIZE must exceed 32 and TIMEOUT_CYCLES must be positive");
  end

  assign hit       = hashReg < targetReg;
  assign lastNonce = curNonce == endNonce;
  assign accept    = (state == IDLE) && job_valid;
  assign sha_msg   = {headerReg, curNonce};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Abort wins over every other event once a job is running, including a coincident sha_done.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (job_valid) nextState = ISSUE;
      ISSUE:   nextState = abort ? IDLE : WAIT;
      WAIT: begin
        if (abort)          nextState = IDLE;
        else if (sha_done)  nextState = CHECK;
        else if (wdExpired) nextState = FINISH;
      end
      CHECK: begin
        if (abort)                 nextState = IDLE;
        else if (hit || lastNonce) nextState = FINISH;
        else                       nextState = ISSUE;
      end
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    job_ready = 1'b0;
    busy      = 1'b1;
    sha_begin = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
      end
      ISSUE:   sha_begin = 1'b1;
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  // Status flags are only ever touched on job acceptance or on a non-aborted WAIT/CHECK cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      headerReg   <= '0;
      curNonce    <= '0;
      endNonce    <= '0;
      targetReg   <= '0;
      hashReg     <= '0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      hash_count  <= '0;
    end else begin
      if (accept) begin
        headerReg   <= header_in;
        curNonce    <= nonce_start;
        endNonce    <= nonce_end;
        targetReg   <= target;
        found       <= 1'b0;
        exhausted   <= 1'b0;
        found_nonce <= '0;
        found_hash  <= '0;
        hash_count  <= '0;
      end
      if (state == WAIT && sha_done && !abort) begin
        hashReg    <= sha_hash;
        hash_count <= hash_count + 32'd1;
      end
      if (state == CHECK && !abort) begin
        if (hit) begin
          found       <= 1'b1;
          found_nonce <= curNonce;
          found_hash  <= hashReg;
        end else if (lastNonce) begin
          exhausted <= 1'b1;
        end else begin
          curNonce <= curNonce + 32'd1;
        end
      end
    end
  end

`ifdef NONCE_SWEEP_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WDW-1:0] wdCount;
  logic           timeoutFlag;

  assign wdExpired   = (state == WAIT) && (wdCount == WDW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeoutFlag;

  // Counter restarts in ISSUE so every WAIT visit gets a full TIMEOUT_CYCLES budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdCount     <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      if (state == ISSUE)     wdCount <= '0;
      else if (state == WAIT) wdCount <= wdCount + 1'b1;
      if (accept)                                timeoutFlag <= 1'b0;
      else if (wdExpired && !abort && !sha_done) timeoutFlag <= 1'b1;
    end
  end
`else
  assign wdExpired   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Self-checking bench for nonce_sweep_ctrl: table-driven sweeps with a nonce scoreboard, plus abort, reset and SHA-stall sequences.
// Define NONCE_SWEEP_WATCHDOG_EN for both files to exercise the watchdog path.
module tb_nonce_sweep_ctrl;

  localparam int TS = 640;
  localparam int HW = TS - 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           job_valid;
  logic           job_ready;
  logic [HW-1:0]  header_in;
  logic [31:0]    nonce_start;
  logic [31:0]    nonce_end;
  logic [255:0]   target;
  logic           abort;
  logic [TS-1:0]  sha_msg;
  logic           sha_begin;
  logic           sha_done;
  logic [255:0]   sha_hash;
  logic           busy;
  logic           done;
  logic           found;
  logic           exhausted;
  logic           timeout_err;
  logic [31:0]    found_nonce;
  logic [255:0]   found_hash;
  logic [31:0]    hash_count;

  int testCount = 0;
  int failCount = 0;
  int beginCount = 0;
  int doneCount = 0;

  logic [31:0] expQ[$];

  typedef struct {
    logic [31:0]  start;
    logic [31:0]  stop;
    logic [255:0] tgt;
    logic [31:0]  hitNonce;
    bit           hitEn;
    logic [255:0] hitHash;
    logic [255:0] missHash;
    bit           expFound;
    bit           expExh;
    logic [31:0]  expNonce;
    logic [31:0]  expCount;
  } vecT;

  vecT vecs[5];

  nonce_sweep_ctrl #(.TOTAL_SIZE(TS), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .header_in(header_in), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .target(target), .abort(abort), .sha_msg(sha_msg), .sha_begin(sha_begin),
    .sha_done(sha_done), .sha_hash(sha_hash), .busy(busy), .done(done),
    .found(found), .exhausted(exhausted), .timeout_err(timeout_err),
    .found_nonce(found_nonce), .found_hash(found_hash), .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sha_begin) beginCount++;
    if (done)      doneCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [255:0] hashFor(input vecT v, input logic [31:0] n);
    return (v.hitEn && n == v.hitNonce) ? v.hitHash : v.missHash;
  endfunction

  task automatic waitBegin(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sha_begin) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Entered at a negedge; leaves at the negedge where the DUT sits in CHECK.
  task automatic serveHash(input logic [31:0] expNonce, input logic [255:0] hash);
    bit ok;
    waitBegin(ok);
    if (!ok) begin
      checkOutput("sha_begin_timeout", {255'b0, sha_begin}, 256'd1);
      return;
    end
    checkOutput("sha_msg_nonce", {224'b0, sha_msg[31:0]}, {224'b0, expNonce});
    checkOutput("sha_msg_header", {255'b0, sha_msg[TS-1:32] == header_in}, 256'd1);
    @(negedge clk);
    sha_done = 1'b1;
    sha_hash = hash;
    @(negedge clk);
    sha_done = 1'b0;
    checkOutput("sha_msg_stable", {224'b0, sha_msg[31:0]}, {224'b0, expNonce});
  endtask

  task automatic startJob(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t);
    for (int i = 0; i < HW / 32; i++) header_in[i*32 +: 32] = $urandom;
    nonce_start = s;
    nonce_end   = e;
    target      = t;
    job_valid   = 1'b1;
    checkOutput("job_ready_idle", {255'b0, job_ready}, 256'd1);
    @(negedge clk);
    job_valid = 1'b0;
    checkOutput("first_begin_latency", {255'b0, sha_begin}, 256'd1);
  endtask

  task automatic applyStimulus(input vecT v);
    logic [31:0] n;
    int b0, d0;
    n = v.start;
    for (int i = 0; i < 64; i++) begin
      expQ.push_back(n);
      if (hashFor(v, n) < v.tgt || n == v.stop) break;
      n = n + 32'd1;
    end
    b0 = beginCount;
    d0 = doneCount;
    startJob(v.start, v.stop, v.tgt);
    while (expQ.size() > 0) begin
      n = expQ.pop_front();
      serveHash(n, hashFor(v, n));
      @(negedge clk);
      if (expQ.size() > 0) checkOutput("rebegin_latency", {255'b0, sha_begin}, 256'd1);
    end
    checkOutput("done_after_check", {255'b0, done}, 256'd1);
    checkOutput("found", {255'b0, found}, {255'b0, v.expFound});
    checkOutput("exhausted", {255'b0, exhausted}, {255'b0, v.expExh});
    checkOutput("hash_count", {224'b0, hash_count}, {224'b0, v.expCount});
    checkOutput("timeout_err", {255'b0, timeout_err}, 256'd0);
    if (v.expFound) begin
      checkOutput("found_nonce", {224'b0, found_nonce}, {224'b0, v.expNonce});
      checkOutput("found_hash", found_hash, hashFor(v, v.expNonce));
    end
    @(negedge clk);
    checkOutput("done_one_cycle", {255'b0, done}, 256'd0);
    checkOutput("job_ready_after", {255'b0, job_ready}, 256'd1);
    checkOutput("found_held", {255'b0, found}, {255'b0, v.expFound});
    checkOutput("begin_pulses", beginCount - b0, {224'b0, v.expCount});
    checkOutput("done_pulses", doneCount - d0, 256'd1);
  endtask

  initial begin
    int d0, cycles;
    bit ok;
    rst = 1'b1; job_valid = 1'b0; abort = 1'b0; sha_done = 1'b0; sha_hash = '0;
    header_in = '0; nonce_start = '0; nonce_end = '0; target = '0;

    vecs[0] = '{32'd5, 32'd7, {256{1'b1}}, 32'd0, 1'b0, 256'd0, 256'h1234, 1'b1, 1'b0, 32'd5, 32'd1};
    vecs[1] = '{32'hFFFF_FFFE, 32'h1, 256'd0, 32'd0, 1'b0, 256'd0, 256'd0, 1'b0, 1'b1, 32'd0, 32'd4};
    vecs[2] = '{32'd10, 32'd20, 256'd100, 32'd13, 1'b1, 256'd5, {256{1'b1}}, 1'b1, 1'b0, 32'd13, 32'd4};
    vecs[3] = '{32'd7, 32'd7, 256'd0, 32'd0, 1'b0, 256'd0, 256'd0, 1'b0, 1'b1, 32'd0, 32'd1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 256'd1, 32'hFFFF_FFFF, 1'b1, 256'd0, {256{1'b1}}, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_job_ready", {255'b0, job_ready}, 256'd1);
    checkOutput("rst_busy", {255'b0, busy}, 256'd0);
    checkOutput("rst_sha_begin", {255'b0, sha_begin}, 256'd0);
    checkOutput("rst_hash_count", {224'b0, hash_count}, 256'd0);
    checkOutput("rst_sha_msg", {255'b0, sha_msg == '0}, 256'd1);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Abort coinciding with sha_done on the fourth nonce, then stray completions while idle.
    d0 = doneCount;
    startJob(32'd0, 32'd10, 256'd0);
    for (int i = 0; i < 3; i++) begin
      serveHash(i[31:0], {256{1'b1}});
      @(negedge clk);
    end
    waitBegin(ok);
    checkOutput("abort_nonce", {224'b0, sha_msg[31:0]}, 256'd3);
    @(negedge clk);
    sha_done = 1'b1; sha_hash = '0; abort = 1'b1;
    @(negedge clk);
    sha_done = 1'b0; abort = 1'b0;
    checkOutput("abort_idle", {255'b0, job_ready}, 256'd1);
    checkOutput("abort_busy", {255'b0, busy}, 256'd0);
    checkOutput("abort_found", {255'b0, found}, 256'd0);
    checkOutput("abort_exhausted", {255'b0, exhausted}, 256'd0);
    checkOutput("abort_hash_count", {224'b0, hash_count}, 256'd3);
    sha_done = 1'b1; sha_hash = '0;
    repeat (2) @(negedge clk);
    sha_done = 1'b0;
    checkOutput("late_done_count", {224'b0, hash_count}, 256'd3);
    checkOutput("late_done_busy", {255'b0, busy}, 256'd0);
    checkOutput("abort_no_done", doneCount - d0, 256'd0);

    // Reset while waiting on the second hash.
    d0 = doneCount;
    startJob(32'd0, 32'd5, 256'd0);
    serveHash(32'd0, {256{1'b1}});
    @(negedge clk);
    waitBegin(ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_job_ready", {255'b0, job_ready}, 256'd1);
    checkOutput("mid_rst_busy", {255'b0, busy}, 256'd0);
    checkOutput("mid_rst_flags", {253'b0, found, exhausted, timeout_err}, 256'd0);
    checkOutput("mid_rst_hash_count", {224'b0, hash_count}, 256'd0);
    checkOutput("mid_rst_sha_msg", {255'b0, sha_msg == '0}, 256'd1);
    checkOutput("mid_rst_no_done", doneCount - d0, 256'd0);

    // SHA block never answers.
    d0 = doneCount;
    startJob(32'd0, 32'd0, 256'd0);
    cycles = 0;
`ifdef NONCE_SWEEP_WATCHDOG_EN
    while (!done && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("wd_latency", cycles, 256'd9);
    checkOutput("wd_timeout_err", {255'b0, timeout_err}, 256'd1);
    checkOutput("wd_found", {255'b0, found}, 256'd0);
    @(negedge clk);
    checkOutput("wd_idle", {255'b0, job_ready}, 256'd1);
`else
    repeat (20) @(negedge clk);
    checkOutput("stall_busy", {255'b0, busy}, 256'd1);
    checkOutput("stall_timeout_err", {255'b0, timeout_err}, 256'd0);
    checkOutput("stall_no_done", doneCount - d0, 256'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("stall_abort_idle", {255'b0, busy}, 256'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
